// File: rtl/exc_sequencer_if.sv
// Trap-sequencer bus: ROB exception commit, pipeline status, IVT lookup and fetch redirect.
// master = pipeline/IVT side, slave = exc_sequencer.
interface exc_sequencer_if;
   logic        rob_exc_valid;
   logic [1:0]  rob_exc_cause;
   logic [15:0] rob_exc_pc;
   logic        pipe_empty;
   logic        eret;
   logic [15:0] handler_address;
   logic [1:0]  ivt_cause;
   logic        flush;
   logic        pc_redirect_valid;
   logic [15:0] pc_redirect_addr;
   logic        exc_ack;
   logic        in_handler;
   logic [15:0] epc;
   logic [1:0]  cause_reg;
   logic [7:0]  exc_count;
   logic        drain_timeout;
   logic        double_fault;

   modport master (
      output rob_exc_valid, rob_exc_cause, rob_exc_pc, pipe_empty, eret, handler_address,
      input  ivt_cause, flush, pc_redirect_valid, pc_redirect_addr, exc_ack, in_handler,
             epc, cause_reg, exc_count, drain_timeout, double_fault
   );

   modport slave (
      input  rob_exc_valid, rob_exc_cause, rob_exc_pc, pipe_empty, eret, handler_address,
      output ivt_cause, flush, pc_redirect_valid, pc_redirect_addr, exc_ack, in_handler,
             epc, cause_reg, exc_count, drain_timeout, double_fault
   );
endinterface

// File: rtl/exc_sequencer.sv
// Trap sequencer: accepts one committed exception, flushes, drains, redirects fetch to the
// IVT handler, and on eret flushes again and resumes past the faulting instruction.
module exc_sequencer #(
   parameter int INSTR_BYTES = 4,
   parameter int DRAIN_MAX   = 16
) (
   input  logic            clk,
   input  logic            reset,
   exc_sequencer_if.slave  sif
);
   localparam int CW = $clog2(DRAIN_MAX);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

   typedef enum logic [5:0] {
      S_IDLE     = 6'b000001,
      S_FLUSH    = 6'b000010,
      S_DRAIN    = 6'b000100,
      S_REDIRECT = 6'b001000,
      S_HANDLER  = 6'b010000,
      S_RETURN   = 6'b100000
   } state_t;

   state_t      r_state;
   logic        r_flush;
   logic        r_redirect;
   logic        r_in_handler;
   logic        r_drain_timeout;
   logic        r_double_fault;
   logic [15:0] r_epc;
   logic [1:0]  r_cause;
   logic [7:0]  r_exc_count;
   logic [CW-1:0] r_drain_cnt;

   logic [15:0] w_return_addr;
   logic [15:0] w_redirect_addr;

   assign w_return_addr = r_epc + 16'(INSTR_BYTES);

   // Handler address comes straight from the IVT, so the redirect target is a mux, not a register.
   always_comb begin
      w_redirect_addr = 16'h0000;
      if (r_state == S_REDIRECT)
         w_redirect_addr = sif.handler_address;
      else if (r_state == S_RETURN)
         w_redirect_addr = w_return_addr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_flush         <= 1'b0;
         r_redirect      <= 1'b0;
         r_in_handler    <= 1'b0;
         r_drain_timeout <= 1'b0;
         r_double_fault  <= 1'b0;
         r_epc           <= 16'h0000;
         r_cause         <= 2'b00;
         r_exc_count     <= 8'h00;
         r_drain_cnt     <= '0;
      end else begin
         // Moore outputs are registered against the state being entered.
         r_flush      <= 1'b0;
         r_redirect   <= 1'b0;
         r_in_handler <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sif.rob_exc_valid) begin
                  r_cause <= sif.rob_exc_cause;
                  r_epc   <= sif.rob_exc_pc;
                  if (r_exc_count != 8'hFF)
                     r_exc_count <= r_exc_count + 8'd1;
                  r_flush <= 1'b1;
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               r_drain_cnt <= '0;
               r_state     <= S_DRAIN;
            end
            S_DRAIN: begin
               if (sif.pipe_empty) begin
                  r_redirect <= 1'b1;
                  r_state    <= S_REDIRECT;
               end else if (r_drain_cnt == DRAIN_LAST) begin
                  r_drain_timeout <= 1'b1;
                  r_redirect      <= 1'b1;
                  r_state         <= S_REDIRECT;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            S_REDIRECT: begin
               r_in_handler <= 1'b1;
               r_state      <= S_HANDLER;
            end
            S_HANDLER: begin
               if (sif.rob_exc_valid)
                  r_double_fault <= 1'b1;
               if (sif.eret) begin
                  r_flush    <= 1'b1;
                  r_redirect <= 1'b1;
                  r_state    <= S_RETURN;
               end else begin
                  r_in_handler <= 1'b1;
               end
            end
            S_RETURN: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign sif.exc_ack           = (r_state == S_IDLE) && sif.rob_exc_valid && !reset;
   assign sif.ivt_cause         = r_cause;
   assign sif.cause_reg         = r_cause;
   assign sif.epc               = r_epc;
   assign sif.flush             = r_flush;
   assign sif.pc_redirect_valid = r_redirect;
   assign sif.pc_redirect_addr  = r_redirect ? w_redirect_addr : 16'h0000;
   assign sif.in_handler        = r_in_handler;
   assign sif.exc_count         = r_exc_count;
   assign sif.drain_timeout     = r_drain_timeout;
   assign sif.double_fault      = r_double_fault;
endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed and randomized traps against a timeline model.
module tb_exc_sequencer;
   localparam int INSTR_BYTES = 4;
   localparam int DRAIN_MAX   = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   exc_sequencer_if bus();

   exc_sequencer #(.INSTR_BYTES(INSTR_BYTES), .DRAIN_MAX(DRAIN_MAX)) dut (
      .clk  (clk),
      .reset(reset),
      .sif  (bus.slave)
   );

   function automatic logic [15:0] ivt(input logic [1:0] c);
      case (c)
         2'd0:    return 16'h02BC;
         2'd1:    return 16'h030C;
         2'd2:    return 16'h02E4;
         default: return 16'h0334;
      endcase
   endfunction

   assign bus.handler_address = ivt(bus.ivt_cause);

   int total = 0;
   int bad   = 0;
   int          cnt_m = 0;
   bit          df_m  = 0;
   bit          to_m  = 0;
   logic [15:0] epc_m = 16'h0;
   logic [1:0]  cause_m = 2'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flush"}, bus.flush, 0);
      chk({tag, "_rv"},    bus.pc_redirect_valid, 0);
      chk({tag, "_ra"},    bus.pc_redirect_addr, 0);
      chk({tag, "_ack"},   bus.exc_ack, 0);
      chk({tag, "_inh"},   bus.in_handler, 0);
      chk({tag, "_epc"},   bus.epc, 0);
      chk({tag, "_cause"}, bus.cause_reg, 0);
      chk({tag, "_ivt"},   bus.ivt_cause, 0);
      chk({tag, "_cnt"},   bus.exc_count, 0);
      chk({tag, "_dto"},   bus.drain_timeout, 0);
      chk({tag, "_dfl"},   bus.double_fault, 0);
   endtask

   // k = cycles after entering DRAIN before pipe_empty first rises (>= DRAIN_MAX: never in time).
   task automatic run_exc(input logic [1:0] c, input logic [15:0] pc, input int k);
      int tr;
      tr = 3 + ((k < DRAIN_MAX - 1) ? k : DRAIN_MAX - 1);
      bus.rob_exc_valid = 1'b1;
      bus.rob_exc_cause = c;
      bus.rob_exc_pc    = pc;
      bus.pipe_empty    = 1'($urandom % 2);
      bus.eret          = 1'b0;
      #1;
      chk("ack", bus.exc_ack, 1);
      chk("ack_flush", bus.flush, 0);
      cyc();
      cnt_m   = (cnt_m < 255) ? cnt_m + 1 : 255;
      epc_m   = pc;
      cause_m = c;
      bus.rob_exc_valid = 1'($urandom % 2);
      bus.rob_exc_cause = 2'($urandom);
      bus.rob_exc_pc    = 16'($urandom);
      #1;
      chk("e1_flush", bus.flush, 1);
      chk("e1_ack",   bus.exc_ack, 0);
      chk("e1_rv",    bus.pc_redirect_valid, 0);
      chk("e1_epc",   bus.epc, epc_m);
      chk("e1_cause", bus.cause_reg, cause_m);
      chk("e1_ivt",   bus.ivt_cause, cause_m);
      chk("e1_cnt",   bus.exc_count, cnt_m);
      for (int t = 2; t <= tr; t++) begin
         cyc();
         bus.pipe_empty    = (t - 2 >= k);
         bus.rob_exc_valid = 1'($urandom % 2);
         bus.rob_exc_cause = 2'($urandom);
         bus.rob_exc_pc    = 16'($urandom);
         bus.eret          = 1'($urandom % 2);
         #1;
         chk($sformatf("drain_rv_t%0d", t), bus.pc_redirect_valid, (t == tr));
         chk($sformatf("drain_ra_t%0d", t), bus.pc_redirect_addr, (t == tr) ? ivt(c) : 16'h0);
         chk("drain_flush", bus.flush, 0);
         chk("drain_ack",   bus.exc_ack, 0);
         chk("drain_inh",   bus.in_handler, 0);
         chk("drain_epc",   bus.epc, epc_m);
      end
      if (k >= DRAIN_MAX) to_m = 1'b1;
      cyc();
      bus.rob_exc_valid = 1'b0;
      bus.eret          = 1'b0;
      #1;
      chk("h_inh",   bus.in_handler, 1);
      chk("h_rv",    bus.pc_redirect_valid, 0);
      chk("h_dto",   bus.drain_timeout, to_m);
      $display("exception cause=%0d pc=%04h k=%0d redirect_at=E+%0d count=%0d", c, pc, k, tr, cnt_m);
   endtask

   task automatic run_handler(input int idle, input bit nest, input bit both);
      for (int i = 0; i < idle; i++) begin
         bus.rob_exc_valid = nest && (i == 0);
         bus.rob_exc_cause = 2'b11;
         bus.rob_exc_pc    = 16'h0200;
         bus.eret          = 1'b0;
         #1;
         chk("hw_inh",   bus.in_handler, 1);
         chk("hw_flush", bus.flush, 0);
         chk("hw_ack",   bus.exc_ack, 0);
         cyc();
         if (nest && i == 0) df_m = 1'b1;
         chk("hw_dfl",   bus.double_fault, df_m);
         chk("hw_epc",   bus.epc, epc_m);
         chk("hw_cause", bus.cause_reg, cause_m);
         chk("hw_cnt",   bus.exc_count, cnt_m);
         chk("hw_flush2", bus.flush, 0);
      end
      bus.eret          = 1'b1;
      bus.rob_exc_valid = both;
      bus.rob_exc_cause = 2'($urandom);
      bus.rob_exc_pc    = 16'($urandom);
      #1;
      chk("eret_ack", bus.exc_ack, 0);
      cyc();
      if (both) df_m = 1'b1;
      bus.eret          = 1'($urandom % 2);
      bus.rob_exc_valid = 1'($urandom % 2);
      #1;
      chk("ret_flush", bus.flush, 1);
      chk("ret_rv",    bus.pc_redirect_valid, 1);
      chk("ret_ra",    bus.pc_redirect_addr, 16'(epc_m + 16'(INSTR_BYTES)));
      chk("ret_inh",   bus.in_handler, 0);
      chk("ret_ack",   bus.exc_ack, 0);
      chk("ret_dfl",   bus.double_fault, df_m);
      cyc();
      bus.eret          = 1'b0;
      bus.rob_exc_valid = 1'b0;
      #1;
      chk("idle_flush", bus.flush, 0);
      chk("idle_rv",    bus.pc_redirect_valid, 0);
      chk("idle_ra",    bus.pc_redirect_addr, 0);
      chk("idle_inh",   bus.in_handler, 0);
      chk("idle_epc",   bus.epc, epc_m);
      chk("idle_cnt",   bus.exc_count, cnt_m);
      $display("return epc=%04h resume=%04h idle=%0d nest=%0d both=%0d dfl=%0d",
               epc_m, 16'(epc_m + 16'(INSTR_BYTES)), idle, nest, both, df_m);
   endtask

   initial begin
      bus.rob_exc_valid = 1'b0;
      bus.rob_exc_cause = 2'b0;
      bus.rob_exc_pc    = 16'h0;
      bus.pipe_empty    = 1'b0;
      bus.eret          = 1'b0;

      // Reset asserted mid-cycle, then released.
      #12 reset = 1'b1;
      #1;
      chk_all_zero("rst_async");
      cyc();
      reset = 1'b0;
      #1;
      chk_all_zero("rst_rel");
      $display("reset check done");

      // Div0 with immediate drain, then return.
      run_exc(2'b01, 16'h0100, 0);
      run_handler(2, 1'b0, 1'b0);

      // Drain timeout, cause 10, with a nested exception.
      run_exc(2'b10, 16'($urandom), 100);
      run_handler(3, 1'b1, 1'b0);

      // eret and rob_exc_valid together.
      run_exc(2'b11, 16'($urandom), 5);
      run_handler(2, 1'b0, 1'b1);

      // PC wrap on return.
      run_exc(2'b00, 16'hFFFE, 1);
      run_handler(1, 1'b0, 1'b0);

      // Randomized traps.
      for (int n = 0; n < 20; n++) begin
         run_exc(2'($urandom), 16'($urandom), int'($urandom_range(0, 20)));
         run_handler(int'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2));
      end

      // Reset while in DRAIN with an exception presented.
      bus.rob_exc_valid = 1'b1;
      bus.rob_exc_cause = 2'b10;
      bus.rob_exc_pc    = 16'h1234;
      bus.pipe_empty    = 1'b0;
      cyc();
      cyc();
      #1 reset = 1'b1;
      #1;
      chk_all_zero("rst_drain");
      cyc();
      chk_all_zero("rst_drain_next");
      bus.rob_exc_valid = 1'b0;
      reset = 1'b0;
      cnt_m = 0; df_m = 1'b0; to_m = 1'b0; epc_m = 16'h0; cause_m = 2'b0;
      #1;
      chk_all_zero("rst_drain_rel");
      $display("reset during drain check done");

      // Saturation of exc_count.
      for (int n = 0; n < 258; n++) begin
         run_exc(2'($urandom), 16'($urandom), 0);
         run_handler(0, 1'b0, 1'b0);
      end
      chk("sat_cnt", bus.exc_count, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Trap sequencer between ROB commit and the fetch PC mux. It accepts one committed exception at a time, latches cause and EPC, and flushes the pipeline. It waits for the pipeline to drain, then drives the latched cause into the IVT and redirects fetch to the returned handler address. On `eret` it flushes again and resumes at EPC + INSTR_BYTES.

## Interface
- INSTR_BYTES, 4, return-address increment; skips the faulting instruction.
- DRAIN_MAX, 16, maximum cycles spent in DRAIN before a forced redirect (≥2).
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- rob_exc_valid  input  1  ROB commits an excepting instruction this cycle
- rob_exc_cause  input  2  00 illegal, 01 div0, 10 load/store, 11 address
- rob_exc_pc  input  16  PC of the excepting instruction
- pipe_empty  input  1  all in-flight instructions gone
- eret  input  1  handler commits return-from-exception
- handler_address  input  16  IVT output for `ivt_cause`
- ivt_cause  output  2  = cause_reg, continuously
- flush  output  1  pipeline flush pulse
- pc_redirect_valid  output  1  fetch must load `pc_redirect_addr`
- pc_redirect_addr  output  16  redirect target
- exc_ack  output  1  one-cycle pulse: exception accepted
- in_handler  output  1  high in HANDLER
- epc  output  16  latched exception PC
- cause_reg  output  2  latched cause
- exc_count  output  8  accepted exceptions, saturates at 255
- drain_timeout  output  1  sticky: a drain hit DRAIN_MAX
- double_fault  output  1  sticky: exception reported while in HANDLER

## Operation
- States: IDLE, FLUSH, DRAIN, REDIRECT, HANDLER, RETURN. All are one-hot-safe; an illegal encoding goes to IDLE.
- IDLE:
  - On rob_exc_valid, latch cause_reg←rob_exc_cause and epc←rob_exc_pc.
  - Increment exc_count (saturating), pulse exc_ack the same cycle (combinational from IDLE && rob_exc_valid).
  - Next state FLUSH.
- FLUSH: flush=1. Clear drain_cnt. Next state DRAIN.
- DRAIN:
  - If pipe_empty, next state REDIRECT.
  - Else if drain_cnt == DRAIN_MAX−1, go to REDIRECT and set drain_timeout.
  - Else drain_cnt++.
- REDIRECT: pc_redirect_valid=1, pc_redirect_addr=handler_address. Next state HANDLER.
- HANDLER:
  - in_handler=1.
  - eret → RETURN.
  - rob_exc_valid without eret → set double_fault; epc, cause_reg and exc_count are unchanged; stay in HANDLER.
  - eret and rob_exc_valid in the same cycle: eret wins, and double_fault is also set.
- RETURN: flush=1, pc_redirect_valid=1, pc_redirect_addr=(epc+INSTR_BYTES) mod 2^16. Next state IDLE.
- Ignored inputs, with no flags set:
  - rob_exc_valid in FLUSH/DRAIN/REDIRECT/RETURN; those instructions are being flushed.
  - eret outside HANDLER.
- Outputs are Moore-decoded from state, except exc_ack. pc_redirect_addr=0 when pc_redirect_valid=0.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - State IDLE.
  - Outputs all 0: flush, pc_redirect_valid, pc_redirect_addr, exc_ack, in_handler, epc, cause_reg, ivt_cause, exc_count, drain_timeout, double_fault.
  - drain_cnt=0.
- Reset mid-operation (any state) → IDLE immediately, all registers cleared, no redirect emitted.
- Exception sampled at edge E:
  - flush in cycle E+1.
  - DRAIN from E+2.
  - If pipe_empty is high in cycle E+2: REDIRECT in E+3, in_handler from E+4. Minimum accept-to-redirect latency is 3 cycles.
- Drain timeout: if pipe_empty is never high, REDIRECT occurs after exactly DRAIN_MAX DRAIN cycles, i.e. cycle E+2+DRAIN_MAX.
- handler_address must be valid combinationally from ivt_cause during REDIRECT. ivt_cause is stable from E+1 onward.
- eret sampled at edge R in HANDLER: RETURN (flush + redirect) in cycle R+1, IDLE in R+2.
- A new exception is accepted no earlier than cycle R+2.

## Test plan
- Reset: assert reset mid-cycle, then release. Required response: every output 0, state IDLE. Then assert rob_exc_valid while in DRAIN and assert reset: IDLE next cycle, epc=0, no pc_redirect_valid.
- Div0 exception, pipe_empty tied high:
  - Stimulus: cause 01, pc 0x0100, IVT model driving 0x02BC/0x030C/0x02E4/0x0334 for causes 00/01/10/11.
  - Required response: exc_ack at E, flush at E+1, redirect at E+3 to 0x030C, in_handler at E+4, epc=0x0100, exc_count=1.
- Return: eret in HANDLER after the div0 case. Required response: next cycle flush=1 and redirect to 0x0104; IDLE after; in_handler=0.
- Drain timeout: pipe_empty held low, DRAIN_MAX=16, cause 10. Required response: redirect to 0x02E4 at E+18, drain_timeout=1.
- Nested exception and priority:
  - In HANDLER, assert rob_exc_valid with cause 11, pc 0x0200. Required: double_fault=1, epc and cause_reg unchanged, no flush.
  - Assert eret and rob_exc_valid together. Required: RETURN taken.
- Wrap and saturation:
  - Illegal exception at pc 0xFFFE. Required: handler redirect to 0x02BC, return redirect to 0x0002.
  - 256 exceptions. Required: exc_count stays 255.
